// File: rtl/ara_vcfg_unit.sv
// ara_vcfg_unit: executes vsetvli / vsetivli / vsetvl and owns the architectural vl and vtype.
// Optional feature macro: ARA_VCFG_FRACT_LMUL_EN enables fractional LMUL (mf2/mf4/mf8);
// without it every fractional vlmul is rejected with vill and no fractional VLMAX shifter exists.
`default_nettype none

module ara_vcfg_unit #(
    parameter int unsigned VLEN = 4096,
    parameter int unsigned ELEN = 64,
    parameter int unsigned XLEN = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [31:0]             req_instr_i,
    input  logic [XLEN-1:0]         req_rs1_i,
    input  logic [XLEN-1:0]         req_rs2_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [4:0]              resp_rd_o,
    output logic [XLEN-1:0]         resp_result_o,
    output logic                    resp_illegal_o,
    output logic [$clog2(VLEN):0]   vl_o,
    output logic [8:0]              vtype_o,
    output logic                    vcfg_update_o
);

    localparam int unsigned VLW = $clog2(VLEN) + 1;
    // Comparison width wide enough for both a full XLEN AVL and a full VLMAX.
    localparam int unsigned CW  = (XLEN > VLW) ? XLEN : VLW;

    localparam logic [6:0] OPC_VECTOR = 7'h57;
    localparam logic [2:0] F3_OPCFG   = 3'b111;
    localparam logic [2:0] LMUL_RSVD  = 3'b100;
    localparam logic [8:0] VTYPE_VILL = 9'h100;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      instr_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [VLW-1:0]   vl_q;
    logic [8:0]       vtype_q;
    logic [4:0]       respRd_q;
    logic [XLEN-1:0]  respResult_q;
    logic             respIllegal_q;
    logic             update_q;

    logic             accept;
    logic [4:0]       rdField;
    logic [4:0]       rs1Field;
    logic             isOpcfg;
    logic             isVsetvli;
    logic             isVsetivli;
    logic             isVsetvl;
    logic             legal;
    logic [7:0]       vtypeSrc;
    logic             rsvdNz;
    logic [2:0]       vsew;
    logic [2:0]       vlmul;
    logic [31:0]      sewBits;
    logic             sewTooWide;
    logic             isFract;
    logic             fractBad;
    logic             vill;
    logic [CW-1:0]    vlmaxBase;
    logic [CW-1:0]    vlmax;
    logic [CW-1:0]    avl;
    logic [CW-1:0]    minVl;
    logic [VLW-1:0]   newVl;
`ifdef ARA_VCFG_FRACT_LMUL_EN
    logic [1:0]       fractK;
`endif

    assign accept = req_valid_i && req_ready_o;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, compute for one cycle, then hold the response until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend only on the registered state.
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
    end

    // Capture the instruction and scalar operands when a request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (accept) begin
            instr_q <= req_instr_i;
            rs1_q   <= req_rs1_i;
            rs2_q   <= req_rs2_i;
        end
    end

    // Decode the registered word and check the requested vtype for legality.
    always_comb begin
        rdField    = instr_q[11:7];
        rs1Field   = instr_q[19:15];
        isOpcfg    = (instr_q[6:0] == OPC_VECTOR) && (instr_q[14:12] == F3_OPCFG);
        isVsetvli  = ~instr_q[31];
        isVsetivli = (instr_q[31:30] == 2'b11);
        isVsetvl   = (instr_q[31:25] == 7'b1000000);
        legal      = isOpcfg && (isVsetvli || isVsetivli || isVsetvl);

        if (isVsetvl) begin
            vtypeSrc = rs2_q[7:0];
            rsvdNz   = |rs2_q[XLEN-1:8];
        end else if (isVsetivli) begin
            vtypeSrc = instr_q[27:20];
            rsvdNz   = |instr_q[29:28];
        end else begin
            vtypeSrc = instr_q[27:20];
            rsvdNz   = |instr_q[30:28];
        end

        vsew       = vtypeSrc[5:3];
        vlmul      = vtypeSrc[2:0];
        sewBits    = 32'd8 << vsew;
        sewTooWide = (sewBits > ELEN);
        isFract    = vlmul[2] && (vlmul != LMUL_RSVD);
`ifdef ARA_VCFG_FRACT_LMUL_EN
        // vlmul 5/6/7 encode LMUL 1/8, 1/4, 1/2.
        fractK   = (~vlmul[1:0]) + 2'd1;
        fractBad = isFract && (sewBits > (ELEN >> fractK));
`else
        fractBad = isFract;
`endif
        vill = rsvdNz || sewTooWide || (vlmul == LMUL_RSVD) || fractBad;
    end

    // VLMAX and the new vl; the AVL is compared at full width so large rs1 values saturate.
    always_comb begin
        vlmaxBase = CW'(VLEN) >> (4'd3 + {1'b0, vsew});
        if (!vlmul[2]) begin
            vlmax = vlmaxBase << vlmul[1:0];
`ifdef ARA_VCFG_FRACT_LMUL_EN
        end else if (isFract) begin
            vlmax = vlmaxBase >> fractK;
`endif
        end else begin
            vlmax = '0;
        end

        if (isVsetivli) begin
            avl = CW'(rs1Field);
        end else if (rs1Field != 5'd0) begin
            avl = CW'(rs1_q);
        end else if (rdField != 5'd0) begin
            avl = '1;
        end else begin
            avl = CW'(vl_q);
        end

        minVl = (avl < vlmax) ? avl : vlmax;
        newVl = VLW'(minVl);
    end

    // Commit vl/vtype at the end of CALC for legal encodings only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vl_q    <= '0;
            vtype_q <= VTYPE_VILL;
        end else if ((state_q == CALC) && legal) begin
            if (vill) begin
                vl_q    <= '0;
                vtype_q <= VTYPE_VILL;
            end else begin
                vl_q    <= newVl;
                vtype_q <= {1'b0, vtypeSrc};
            end
        end
    end

    // Build the response at the end of CALC and hold it through backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            respRd_q      <= '0;
            respResult_q  <= '0;
            respIllegal_q <= 1'b0;
        end else if (state_q == CALC) begin
            respRd_q      <= rdField;
            respIllegal_q <= ~legal;
            respResult_q  <= (legal && !vill) ? XLEN'(newVl) : '0;
        end
    end

    // Single-cycle update strobe for the dispatcher, high in the first RESP cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_q <= 1'b0;
        end else begin
            update_q <= (state_q == CALC) && legal;
        end
    end

    assign resp_rd_o      = respRd_q;
    assign resp_result_o  = respResult_q;
    assign resp_illegal_o = respIllegal_q;
    assign vl_o           = vl_q;
    assign vtype_o        = vtype_q;
    assign vcfg_update_o  = update_q;

endmodule

`default_nettype wire
